// File: rtl/morph_pkg.sv
// Shared constants and helpers for the binary morphology stage.
package morph_pkg;

    localparam logic MODE_ERODE  = 1'b0;
    localparam logic MODE_DILATE = 1'b1;

    // Minimum number of bits needed to address value entries (never less than 1).
    function automatic int clog2(input int value);
        int width;
        width = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) width = i + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/line_buffer_1bit.sv
// One line of 1-bit pixel storage; the old bit is read at the address that is being written.
module line_buffer_1bit
    import morph_pkg::*;
#(
    parameter int DEPTH = 480,
    localparam int ADDR_W = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic              din,
    output logic              dout
);

    logic mem [DEPTH];

    assign dout = mem[addr];

    // Contents carry no reset; writes are held off while reset is asserted.
    always_ff @(posedge clk) begin
        if (we && rst_n) mem[addr] <= din;
    end

endmodule

// File: rtl/morph_filter.sv
// Binary erosion/dilation over a causal KSIZE x KSIZE window with border-neutral masking.
module morph_filter
    import morph_pkg::*;
#(
    parameter int H_DISP = 480,
    parameter int V_DISP = 272,
    parameter int KSIZE  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mode,
    input  logic       bina_de,
    input  logic       bina_hsync,
    input  logic       bina_vsync,
    input  logic [7:0] bina_data,
    output logic       morph_de,
    output logic       morph_hsync,
    output logic       morph_vsync,
    output logic [7:0] morph_data
);

    localparam int COL_W = clog2(H_DISP);
    localparam int ROW_W = clog2(V_DISP);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_DISP - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_DISP - 1);

    if (KSIZE != 3 && KSIZE != 5) begin : g_bad_ksize
        $error("morph_filter: KSIZE must be 3 or 5, got %0d", KSIZE);
    end

    function automatic logic reduce_bits(input logic [KSIZE-1:0] bits, input logic dilate);
        return (dilate == MODE_DILATE) ? |bits : &bits;
    endfunction

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             de_q;
    logic             vsync_q;
    logic             mode_r;
    logic             de_fall;
    logic             vsync_rise;
    logic [KSIZE-1:0] tap;
    logic [KSIZE-1:0] row_mask;
    logic [KSIZE-1:0] col_mask;

    assign de_fall    = de_q & ~bina_de;
    assign vsync_rise = bina_vsync & ~vsync_q;
    assign tap[0]     = |bina_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col     <= '0;
            row     <= '0;
            de_q    <= 1'b0;
            vsync_q <= 1'b0;
            mode_r  <= MODE_ERODE;
        end else begin
            de_q    <= bina_de;
            vsync_q <= bina_vsync;
            if (vsync_rise) mode_r <= mode;
            if (bina_de) begin
                if (col != COL_LAST) col <= col + COL_W'(1);
            end else if (de_q) begin
                col <= '0;
            end
            if (vsync_rise) begin
                row <= '0;
            end else if (de_fall && row != ROW_LAST) begin
                row <= row + ROW_W'(1);
            end
        end
    end

    // Tap k holds the bit at the same column from k lines earlier.
    for (genvar k = 1; k < KSIZE; k++) begin : g_lb
        line_buffer_1bit #(
            .DEPTH(H_DISP)
        ) u_lb (
            .clk  (clk),
            .rst_n(rst_n),
            .we   (bina_de),
            .addr (col),
            .din  (tap[k-1]),
            .dout (tap[k])
        );
    end

    always_comb begin
        row_mask = '0;
        col_mask = '0;
        for (int k = 0; k < KSIZE; k++) begin
            row_mask[k] = (int'(row) < k);
            col_mask[k] = (int'(col) < k);
        end
    end

    // Stage 1: window registers (bit c of win_p1[r] is pixel at row-r, col-c) plus border masks.
    logic [KSIZE-1:0] win_p1 [KSIZE];
    logic [KSIZE-1:0] row_mask_p1;
    logic [KSIZE-1:0] col_mask_p1;
    logic             mode_p1;
    logic             de_p1;
    logic             hsync_p1;
    logic             vsync_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < KSIZE; r++) win_p1[r] <= '0;
            row_mask_p1 <= '0;
            col_mask_p1 <= '0;
            mode_p1     <= MODE_ERODE;
            de_p1       <= 1'b0;
            hsync_p1    <= 1'b0;
            vsync_p1    <= 1'b0;
        end else begin
            if (bina_de) begin
                for (int r = 0; r < KSIZE; r++) win_p1[r] <= {win_p1[r][KSIZE-2:0], tap[r]};
            end
            row_mask_p1 <= row_mask;
            col_mask_p1 <= col_mask;
            mode_p1     <= mode_r;
            de_p1       <= bina_de;
            hsync_p1    <= bina_hsync;
            vsync_p1    <= bina_vsync;
        end
    end

    // Stage 2: replace out-of-frame positions with the neutral value, then reduce each row.
    logic [KSIZE-1:0] eff [KSIZE];
    logic [KSIZE-1:0] row_red;
    logic [KSIZE-1:0] row_red_p2;
    logic             mode_p2;
    logic             de_p2;
    logic             hsync_p2;
    logic             vsync_p2;

    always_comb begin
        row_red = '0;
        for (int r = 0; r < KSIZE; r++) begin
            eff[r] = win_p1[r];
            for (int c = 0; c < KSIZE; c++) begin
                if (row_mask_p1[r] || col_mask_p1[c]) eff[r][c] = (mode_p1 == MODE_ERODE);
            end
            row_red[r] = reduce_bits(eff[r], mode_p1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_red_p2 <= '0;
            mode_p2    <= MODE_ERODE;
            de_p2      <= 1'b0;
            hsync_p2   <= 1'b0;
            vsync_p2   <= 1'b0;
        end else begin
            row_red_p2 <= row_red;
            mode_p2    <= mode_p1;
            de_p2      <= de_p1;
            hsync_p2   <= hsync_p1;
            vsync_p2   <= vsync_p1;
        end
    end

    // Stage 3: column reduce; blanking cycles always emit zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            morph_data  <= 8'h00;
            morph_de    <= 1'b0;
            morph_hsync <= 1'b0;
            morph_vsync <= 1'b0;
        end else begin
            morph_data  <= (de_p2 && reduce_bits(row_red_p2, mode_p2)) ? 8'hFF : 8'h00;
            morph_de    <= de_p2;
            morph_hsync <= hsync_p2;
            morph_vsync <= vsync_p2;
        end
    end

endmodule

// File: tb/tb_morph_filter.sv
// Directed bench for morph_filter: 16x8 frames through a KSIZE=3 and a KSIZE=5 instance.
module tb_morph_filter;

    localparam int W = 16;
    localparam int H = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mode = 1'b0;
    logic       bina_de = 1'b0;
    logic       bina_hsync = 1'b0;
    logic       bina_vsync = 1'b0;
    logic [7:0] bina_data = 8'h00;
    logic       de3, hs3, vs3, de5, hs5, vs5;
    logic [7:0] d3, d5;

    always #5 clk = ~clk;

    morph_filter #(.H_DISP(W), .V_DISP(H), .KSIZE(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .bina_de(bina_de), .bina_hsync(bina_hsync),
        .bina_vsync(bina_vsync), .bina_data(bina_data), .morph_de(de3), .morph_hsync(hs3),
        .morph_vsync(vs3), .morph_data(d3));

    morph_filter #(.H_DISP(W), .V_DISP(H), .KSIZE(5)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .bina_de(bina_de), .bina_hsync(bina_hsync),
        .bina_vsync(bina_vsync), .bina_data(bina_data), .morph_de(de5), .morph_hsync(hs5),
        .morph_vsync(vs5), .morph_data(d5));

    int n_checks = 0;
    int n_fail = 0;

    logic       frame_in [H][W];
    logic [7:0] cap3 [H][W];
    logic [7:0] cap5 [H][W];
    logic [7:0] exp_v;
    int row3 = 0, col3 = 0, row5 = 0, col5 = 0;
    logic pde3 = 1'b0, pvs3 = 1'b0, pde5 = 1'b0, pvs5 = 1'b0;
    int idle_bad3 = 0;
    int cyc = 0;
    logic [2:0] in_hist [4096];
    logic [2:0] out_hist3 [4096];

    // Output monitor: records syncs per cycle and places pixels into capture frames.
    always @(negedge clk) begin
        if (cyc < 4096) begin
            in_hist[cyc]   = {bina_de, bina_hsync, bina_vsync};
            out_hist3[cyc] = {de3, hs3, vs3};
        end
        cyc++;
        if (!de3 && d3 !== 8'h00) idle_bad3++;
        if (vs3 && !pvs3) begin row3 = 0; col3 = 0; end
        if (de3) begin
            if (row3 < H && col3 < W) cap3[row3][col3] = d3;
            col3++;
        end else if (pde3) begin
            row3++; col3 = 0;
        end
        pde3 = de3; pvs3 = vs3;
        if (vs5 && !pvs5) begin row5 = 0; col5 = 0; end
        if (de5) begin
            if (row5 < H && col5 < W) cap5[row5][col5] = d5;
            col5++;
        end else if (pde5) begin
            row5++; col5 = 0;
        end
        pde5 = de5; pvs5 = vs5;
    end

    task automatic drive_cycle(input logic de, input logic hs, input logic vs, input logic [7:0] d);
        bina_de = de; bina_hsync = hs; bina_vsync = vs; bina_data = d;
        @(posedge clk); #1;
    endtask

    task automatic fill_frame(input logic v);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) frame_in[r][c] = v;
    endtask

    // Drives one frame from frame_in; mode flips to ~m0 at the start of flip_row (if >= 0).
    task automatic drive_frame(input logic m0, input int flip_row);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin cap3[r][c] = 'x; cap5[r][c] = 'x; end
        idle_bad3 = 0;
        cyc = 0;
        mode = m0;
        drive_cycle(1'b0, 1'b0, 1'b1, 8'h00);
        drive_cycle(1'b0, 1'b0, 1'b1, 8'h00);
        drive_cycle(1'b0, 1'b0, 1'b0, 8'hFF);
        drive_cycle(1'b0, 1'b0, 1'b0, 8'hFF);
        for (int r = 0; r < H; r++) begin
            if (r == flip_row) mode = ~m0;
            drive_cycle(1'b0, 1'b1, 1'b0, 8'hFF);
            drive_cycle(1'b0, 1'b1, 1'b0, 8'hFF);
            drive_cycle(1'b0, 1'b0, 1'b0, 8'h5A);
            drive_cycle(1'b0, 1'b0, 1'b0, 8'h5A);
            for (int c = 0; c < W; c++)
                drive_cycle(1'b1, 1'b0, 1'b0, frame_in[r][c] ? 8'(1 << (c % 8)) : 8'h00);
            for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, 1'b0, 8'hFF);
        end
        for (int i = 0; i < 8; i++) drive_cycle(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    function automatic logic [7:0] model(input int k, input logic dil, input int r, input int c);
        logic acc;
        logic b;
        acc = ~dil;
        for (int dr = 0; dr < k; dr++)
            for (int dc = 0; dc < k; dc++) begin
                if (r - dr < 0 || c - dc < 0) b = ~dil;
                else b = frame_in[r-dr][c-dc];
                acc = dil ? (acc | b) : (acc & b);
            end
        return acc ? 8'hFF : 8'h00;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        bina_de = 1'b1; bina_hsync = 1'b1; bina_vsync = 1'b1; bina_data = 8'hFF;
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if ({de3, hs3, vs3} !== 3'b000) begin
            n_fail++; $display("FAIL reset_sync3: got %b want 000", {de3, hs3, vs3});
        end
        n_checks++;
        if (d3 !== 8'h00) begin n_fail++; $display("FAIL reset_data3: got %h want 00", d3); end
        n_checks++;
        if ({de5, hs5, vs5} !== 3'b000) begin
            n_fail++; $display("FAIL reset_sync5: got %b want 000", {de5, hs5, vs5});
        end
        n_checks++;
        if (d5 !== 8'h00) begin n_fail++; $display("FAIL reset_data5: got %h want 00", d5); end
        bina_de = 1'b0; bina_hsync = 1'b0; bina_vsync = 1'b0; bina_data = 8'h00;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_all_ones();
        fill_frame(1'b1);
        drive_frame(1'b0, -1);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                n_checks++;
                if (cap3[r][c] !== 8'hFF) begin
                    n_fail++; $display("FAIL ones_k3 (%0d,%0d): got %h want FF", r, c, cap3[r][c]);
                end
                n_checks++;
                if (cap5[r][c] !== 8'hFF) begin
                    n_fail++; $display("FAIL ones_k5 (%0d,%0d): got %h want FF", r, c, cap5[r][c]);
                end
            end
        for (int c = 3; c < cyc && c < 4096; c++) begin
            n_checks++;
            if (out_hist3[c] !== in_hist[c-3]) begin
                n_fail++;
                $display("FAIL sync_delay cycle %0d: got de/hs/vs %b want %b", c, out_hist3[c], in_hist[c-3]);
            end
        end
        n_checks++;
        if (idle_bad3 !== 0) begin
            n_fail++; $display("FAIL idle_zero: got %0d nonzero blank cycles want 0", idle_bad3);
        end
    endtask

    task automatic test_erode_hole();
        fill_frame(1'b1);
        frame_in[4][5] = 1'b0;
        drive_frame(1'b0, -1);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                exp_v = (r >= 4 && r <= 6 && c >= 5 && c <= 7) ? 8'h00 : 8'hFF;
                n_checks++;
                if (cap3[r][c] !== exp_v) begin
                    n_fail++; $display("FAIL erode_hole (%0d,%0d): got %h want %h", r, c, cap3[r][c], exp_v);
                end
            end
    endtask

    task automatic test_dilate_k5();
        fill_frame(1'b0);
        frame_in[2][2] = 1'b1;
        drive_frame(1'b1, -1);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                exp_v = (r >= 2 && r <= 6 && c >= 2 && c <= 6) ? 8'hFF : 8'h00;
                n_checks++;
                if (cap5[r][c] !== exp_v) begin
                    n_fail++; $display("FAIL dilate_k5 (%0d,%0d): got %h want %h", r, c, cap5[r][c], exp_v);
                end
                exp_v = (r >= 2 && r <= 4 && c >= 2 && c <= 4) ? 8'hFF : 8'h00;
                n_checks++;
                if (cap3[r][c] !== exp_v) begin
                    n_fail++; $display("FAIL dilate_k3 (%0d,%0d): got %h want %h", r, c, cap3[r][c], exp_v);
                end
            end
    endtask

    task automatic test_mode_toggle();
        fill_frame(1'b0);
        frame_in[3][3] = 1'b1;
        drive_frame(1'b0, 2);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                n_checks++;
                if (cap3[r][c] !== 8'h00) begin
                    n_fail++; $display("FAIL toggle_frame1 (%0d,%0d): got %h want 00", r, c, cap3[r][c]);
                end
            end
        drive_frame(1'b1, -1);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                exp_v = (r >= 3 && r <= 5 && c >= 3 && c <= 5) ? 8'hFF : 8'h00;
                n_checks++;
                if (cap3[r][c] !== exp_v) begin
                    n_fail++; $display("FAIL toggle_frame2 (%0d,%0d): got %h want %h", r, c, cap3[r][c], exp_v);
                end
            end
    endtask

    task automatic test_no_leak();
        fill_frame(1'b1);
        for (int c = 0; c < W; c++) frame_in[H-1][c] = 1'b0;
        drive_frame(1'b0, -1);
        fill_frame(1'b1);
        drive_frame(1'b0, -1);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                n_checks++;
                if (cap3[r][c] !== 8'hFF) begin
                    n_fail++; $display("FAIL no_leak (%0d,%0d): got %h want FF", r, c, cap3[r][c]);
                end
            end
    endtask

    task automatic test_reset_mid();
        fill_frame(1'b1);
        mode = 1'b0;
        drive_cycle(1'b0, 1'b0, 1'b1, 8'h00);
        drive_cycle(1'b0, 1'b0, 1'b1, 8'h00);
        drive_cycle(1'b0, 1'b0, 1'b0, 8'h00);
        drive_cycle(1'b0, 1'b1, 1'b0, 8'h00);
        drive_cycle(1'b0, 1'b0, 1'b0, 8'h00);
        for (int c = 0; c < W; c++) drive_cycle(1'b1, 1'b0, 1'b0, 8'h10);
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, 1'b0, 8'h00);
        drive_cycle(1'b0, 1'b1, 1'b0, 8'h00);
        for (int c = 0; c < 6; c++) drive_cycle(1'b1, 1'b0, 1'b0, 8'h10);
        n_checks++;
        if ({de3, d3} !== {1'b1, 8'hFF}) begin
            n_fail++; $display("FAIL pre_reset_out: got de=%b data=%h want de=1 data=FF", de3, d3);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({de3, hs3, vs3, d3} !== 11'd0) begin
            n_fail++; $display("FAIL mid_reset_k3: got de/hs/vs=%b data=%h want 0", {de3, hs3, vs3}, d3);
        end
        n_checks++;
        if ({de5, hs5, vs5, d5} !== 11'd0) begin
            n_fail++; $display("FAIL mid_reset_k5: got de/hs/vs=%b data=%h want 0", {de5, hs5, vs5}, d5);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b0, 1'b0, 8'h00);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) frame_in[r][c] = ((r * 5 + c * 3) % 7) != 0;
        drive_frame(1'b0, -1);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                exp_v = model(3, 1'b0, r, c);
                n_checks++;
                if (cap3[r][c] !== exp_v) begin
                    n_fail++; $display("FAIL post_reset_k3 (%0d,%0d): got %h want %h", r, c, cap3[r][c], exp_v);
                end
                exp_v = model(5, 1'b0, r, c);
                n_checks++;
                if (cap5[r][c] !== exp_v) begin
                    n_fail++; $display("FAIL post_reset_k5 (%0d,%0d): got %h want %h", r, c, cap5[r][c], exp_v);
                end
            end
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_erode_hole();
        test_dilate_k5();
        test_mode_toggle();
        test_no_leak();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/morph_filter.md
# morph_filter

Parametrised binary morphology stage for the lane-detection video pipeline, following the binarisation step and feeding the Hough stage. Performs erosion or dilation with a square KSIZE×KSIZE structuring element (3 or 5). Mode is selectable per frame and image borders are handled explicitly. Pixels are stored internally as 1 bit, and the stage has a fixed 3-clock latency with de/hsync/vsync delayed to match.

## Interface
- H_DISP, 12'd480, active pixels per line (line-buffer depth)
- V_DISP, 12'd272, active lines per frame
- KSIZE, 3, kernel size; legal values 3 or 5, anything else is an elaboration error
- clk  in  1  pixel clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- mode  in  1  0 = erode, 1 = dilate; latched on bina_vsync rising edge
- bina_de  in  1  input data enable
- bina_hsync  in  1  input line sync
- bina_vsync  in  1  input frame sync
- bina_data  in  8  input pixel; treated as 1 when non-zero
- morph_de  out  1  bina_de delayed 3 clk
- morph_hsync  out  1  bina_hsync delayed 3 clk
- morph_vsync  out  1  bina_vsync delayed 3 clk
- morph_data  out  8  8'hFF if the result bit is 1, else 8'h00

## Operation
- Binarise: b = |bina_data.
- Column counter col (0..H_DISP-1):
  - increments on each bina_de cycle
  - clears on the falling edge of bina_de
- Row counter row (0..V_DISP-1):
  - increments on each bina_de falling edge
  - clears on bina_vsync rising edge
  - saturates at V_DISP-1
- Line buffers: KSIZE-1 cascaded 1-bit line buffers, each H_DISP deep, written only when bina_de=1. Buffer k outputs the bit at the same col from k lines earlier.
- Window (causal): rows row-KSIZE+1..row, columns col-KSIZE+1..col, built from the line-buffer taps plus a KSIZE-deep horizontal shift register per row. The shift registers advance only when bina_de=1.
- Border handling: a window position whose row index < 0 or column index < 0 takes the neutral value, 1 for erode and 0 for dilate. Consequences:
  - The first KSIZE-1 rows and columns are not forced to 0.
  - No data from the previous line or frame leaks into the window.
- Reduce:
  - Erode: result = AND of all KSIZE² bits.
  - Dilate: result = OR of all KSIZE² bits.
- Mode latch: mode_r captures mode on bina_vsync rising edge. A change to mode mid-frame has no effect until the next frame.
- When bina_de=0 the pipeline still advances, but morph_data is forced to 8'h00 for cycles where the delayed de is 0.

## Timing
- Latency is exactly 3 clk for data and syncs, for both KSIZE values:
  - clk1: register window plus border masks
  - clk2: per-row AND/OR reduce, registered
  - clk3: column reduce, registered
- Reset values:
  - All outputs 0; morph_data = 8'h00.
  - col, row, mode_r = 0.
  - Shift registers 0.
  - Line-buffer contents are don't-care, because the border mask covers rows < KSIZE-1.
- Reset asserted mid-frame: outputs go to 0 immediately (asynchronous). The next valid output is after a vsync rising edge.
- bina_de gaps inside a line (de low, then high again) are not supported: each de falling edge counts as a line end.
- Frames with more than V_DISP lines: row saturates and the border mask stays off.

## Structure
- Shared package `morph_pkg`:
  - MODE_ERODE = 1'b0, MODE_DILATE = 1'b1
  - function clog2 for counter widths
- Sub-module `line_buffer_1bit`: parameter DEPTH; ports clk, rst_n, we, din, dout (read-before-write at the same address). It is instantiated KSIZE-1 times. Address is col, shared from the parent.

## Test plan
- KSIZE=3, erode, all-ones 16×8 frame: every morph_data = 8'hFF, including row 0 and col 0; de/hsync/vsync match the input delayed by exactly 3 clk.
- KSIZE=3, erode, single 0 pixel at (row 4, col 5) in an all-ones frame: outputs at rows 4..6, cols 5..7 are 8'h00 (9 pixels); all other pixels are 8'hFF.
- KSIZE=5, dilate, single 1 pixel at (row 2, col 2) in an all-zeros frame: outputs at rows 2..6, cols 2..6 are 8'hFF (25 pixels); all other pixels are 8'h00.
- Mode toggled from 0 to 1 mid-frame: the current frame stays eroded; the next frame is dilated. Check with a single-1 pattern: no output in frame 1, a 3×3 block in frame 2.
- Row 0 of frame 2 after a frame-1 bottom row of zeros (erode): frame-2 row 0 output is all 8'hFF, so there is no inter-frame leakage.
- rst_n pulsed low for 2 clk mid-line: all outputs are 0 within the same cycle. After the next vsync, the frame matches the golden model bit-exactly.
